// File: rtl/uart_tx_fifo_pkg.sv
// Shared UART byte width and transmit-side FSM encodings.
// Imported by the FIFO, the top and anything sharing the uart_tx states.
package uart_tx_fifo_pkg;

   localparam int UART_DATA_W = 8;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      START     = 2'd1,
      WAIT_DONE = 2'd2
   } tx_state_e;

endpackage

// File: rtl/uart_tx_fifo_if.sv
// Host write port plus uart_tx handshake for the transmit FIFO.
// The master drives bytes and tx_busy; the slave is the FIFO block.
interface uart_tx_fifo_if #(
   parameter int DATA_W = 8,
   parameter int ADDR_W = 4
);

   logic              wr_en;
   logic [DATA_W-1:0] wr_data;
   logic              full;
   logic              empty;
   logic [ADDR_W:0]   count;
   logic              overflow;
   logic              clr_ovf;
   logic              tx_start;
   logic [DATA_W-1:0] tx_data;
   logic              tx_busy;

   modport master (
      output wr_en, wr_data, clr_ovf, tx_busy,
      input  full, empty, count, overflow, tx_start, tx_data
   );

   modport slave (
      input  wr_en, wr_data, clr_ovf, tx_busy,
      output full, empty, count, overflow, tx_start, tx_data
   );

endinterface

// File: rtl/uart_tx_fifo_sync_fifo.sv
// Synchronous FIFO: storage, extended pointers, registered full/empty,
// occupancy count and a sticky overflow flag.
module uart_tx_fifo_sync_fifo #(
   parameter int DATA_W = 8,
   parameter int ADDR_W = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              wr_en,
   input  logic [DATA_W-1:0] wr_data,
   input  logic              rd_en,
   output logic [DATA_W-1:0] rd_data,
   input  logic              clr_ovf,
   output logic              full,
   output logic              empty,
   output logic [ADDR_W:0]   count,
   output logic              overflow
);

   localparam int DEPTH = 2 ** ADDR_W;

   logic [DATA_W-1:0] mem [DEPTH];
   logic [ADDR_W:0]   wr_ptr;
   logic [ADDR_W:0]   rd_ptr;
   logic [ADDR_W:0]   wr_ptr_nx;
   logic [ADDR_W:0]   rd_ptr_nx;
   logic              wr_ok;
   logic              rd_ok;

   // Full is judged on the registered flag, so a pop never frees room
   // for a write landing in the same cycle.
   assign wr_ok = wr_en & ~full;
   assign rd_ok = rd_en & ~empty;

   assign wr_ptr_nx = wr_ptr + {{ADDR_W{1'b0}}, wr_ok};
   assign rd_ptr_nx = rd_ptr + {{ADDR_W{1'b0}}, rd_ok};

   assign rd_data = mem[rd_ptr[ADDR_W-1:0]];
   assign count   = wr_ptr - rd_ptr;

   always_ff @(posedge clk) begin
      if (wr_ok) begin
         mem[wr_ptr[ADDR_W-1:0]] <= wr_data;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         full     <= 1'b0;
         empty    <= 1'b1;
         overflow <= 1'b0;
      end else begin
         wr_ptr <= wr_ptr_nx;
         rd_ptr <= rd_ptr_nx;
         full   <= (wr_ptr_nx[ADDR_W] != rd_ptr_nx[ADDR_W]) &&
                   (wr_ptr_nx[ADDR_W-1:0] == rd_ptr_nx[ADDR_W-1:0]);
         empty  <= (wr_ptr_nx == rd_ptr_nx);
         if (wr_en && full) begin
            overflow <= 1'b1;
         end else if (clr_ovf) begin
            overflow <= 1'b0;
         end
      end
   end

endmodule

// File: rtl/uart_tx_fifo.sv
// Byte buffer ahead of uart_tx: pops one byte per frame, raises tx_start
// and holds it until uart_tx reports busy, then waits for the frame end.
module uart_tx_fifo
   import uart_tx_fifo_pkg::*;
#(
   parameter int DATA_W = UART_DATA_W,
   parameter int ADDR_W = 4
) (
   input  logic           clk,
   input  logic           rst_n,
   uart_tx_fifo_if.slave  bus
);

   tx_state_e         state_q;
   tx_state_e         state_d;
   logic              pop;
   logic              tx_start_q;
   logic              tx_start_d;
   logic [DATA_W-1:0] tx_data_q;
   logic [DATA_W-1:0] rd_data;
   logic              fifo_empty;

   uart_tx_fifo_sync_fifo #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W)
   ) u_fifo (
      .clk      (clk),
      .rst_n    (rst_n),
      .wr_en    (bus.wr_en),
      .wr_data  (bus.wr_data),
      .rd_en    (pop),
      .rd_data  (rd_data),
      .clr_ovf  (bus.clr_ovf),
      .full     (bus.full),
      .empty    (fifo_empty),
      .count    (bus.count),
      .overflow (bus.overflow)
   );

   assign bus.empty    = fifo_empty;
   assign bus.tx_start = tx_start_q;
   assign bus.tx_data  = tx_data_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         tx_start_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         tx_start_q <= tx_start_d;
      end
   end

   // A busy line already high on entering START counts as the ack.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:      if (!fifo_empty) state_d = START;
         START:     if (bus.tx_busy) state_d = WAIT_DONE;
         WAIT_DONE: if (!bus.tx_busy) state_d = IDLE;
         default:   state_d = IDLE;
      endcase
   end

   always_comb begin
      pop        = (state_q == IDLE) && !fifo_empty;
      tx_start_d = (state_d == START);
   end

   // Loaded only on a pop, so it stays put for the whole frame.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tx_data_q <= '0;
      end else if (pop) begin
         tx_data_q <= rd_data;
      end
   end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: behavioural uart_tx responder with a byte
// scoreboard, plus directed latency, overflow, push+pop and reset cases.
module tb_uart_tx_fifo;

   localparam int DW = 8;
   localparam int AW = 4;

   logic clk = 1'b0;
   logic rst_n = 1'b0;

   always #5 clk = ~clk;

   uart_tx_fifo_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

   uart_tx_fifo #(.DATA_W(DW), .ADDR_W(AW)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int errors = 0;
   int checks = 0;

   bit         ack_en = 1'b0;
   int         ack_dly_max = 0;
   int         busy_min = 1;
   int         busy_max = 1;
   logic [7:0] exp_q [$];
   int         n_sent = 0;
   int         n_rx = 0;

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // uart_tx stand-in: ack after a random delay, stay busy a random time.
   initial begin
      int d;
      int len;
      logic [7:0] want;
      bus.tx_busy = 1'b0;
      forever begin
         @(posedge clk);
         #2;
         if (rst_n && ack_en && bus.tx_start) begin
            d = $urandom_range(ack_dly_max, 0);
            repeat (d) begin
               @(posedge clk);
               #2;
               chk("start_held", {31'd0, bus.tx_start}, 32'd1);
            end
            if (exp_q.size() == 0) begin
               chk("unexpected_frame", 32'd1, 32'd0);
               want = bus.tx_data;
            end else begin
               want = exp_q.pop_front();
               chk("rx_byte", {24'd0, bus.tx_data}, {24'd0, want});
            end
            n_rx++;
            bus.tx_busy = 1'b1;
            len = $urandom_range(busy_max, busy_min);
            for (int k = 0; k < len; k++) begin
               @(posedge clk);
               #2;
               if (!rst_n) break;
               chk("start_low_busy", {31'd0, bus.tx_start}, 32'd0);
               chk("data_stable", {24'd0, bus.tx_data}, {24'd0, want});
            end
            bus.tx_busy = 1'b0;
         end
      end
   end

   task automatic push(input logic [7:0] b);
      bus.wr_en   = 1'b1;
      bus.wr_data = b;
      @(negedge clk);
      bus.wr_en   = 1'b0;
   endtask

   task automatic push_q(input logic [7:0] b);
      exp_q.push_back(b);
      n_sent++;
      push(b);
   endtask

   task automatic wait_drain(input string tag);
      int t;
      t = 0;
      while ((n_rx != n_sent || bus.tx_busy || !bus.empty) && t < 3000) begin
         @(negedge clk);
         t++;
      end
      repeat (2) @(negedge clk);
      chk(tag, {31'd0, t < 3000}, 32'd1);
      chk({tag, "_count"}, {27'd0, bus.count}, 32'd0);
      chk({tag, "_left"}, exp_q.size(), 32'd0);
   endtask

   initial begin
      int t;
      int wrote;
      bus.wr_en   = 1'b0;
      bus.wr_data = '0;
      bus.clr_ovf = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_full", {31'd0, bus.full}, 32'd0);
      chk("rst_empty", {31'd0, bus.empty}, 32'd1);
      chk("rst_count", {27'd0, bus.count}, 32'd0);
      chk("rst_ovf", {31'd0, bus.overflow}, 32'd0);
      chk("rst_start", {31'd0, bus.tx_start}, 32'd0);
      chk("rst_data", {24'd0, bus.tx_data}, 32'd0);
      rst_n = 1'b1;
      @(negedge clk);

      // Single byte latency, uart_tx not yet answering.
      push_q(8'h55);
      chk("lat_empty", {31'd0, bus.empty}, 32'd0);
      chk("lat_count", {27'd0, bus.count}, 32'd1);
      chk("lat_start0", {31'd0, bus.tx_start}, 32'd0);
      @(negedge clk);
      chk("pop_empty", {31'd0, bus.empty}, 32'd1);
      chk("pop_count", {27'd0, bus.count}, 32'd0);
      chk("pop_start", {31'd0, bus.tx_start}, 32'd1);
      chk("pop_data", {24'd0, bus.tx_data}, 32'h55);
      repeat (3) @(negedge clk);
      chk("start_hold", {31'd0, bus.tx_start}, 32'd1);

      // Fill behind the stalled frame.
      for (int i = 0; i < 16; i++) push_q(i[7:0]);
      chk("fill_full", {31'd0, bus.full}, 32'd1);
      chk("fill_count", {27'd0, bus.count}, 32'd16);
      chk("fill_ovf", {31'd0, bus.overflow}, 32'd0);
      push(8'hAA);
      chk("drop_ovf", {31'd0, bus.overflow}, 32'd1);
      chk("drop_count", {27'd0, bus.count}, 32'd16);
      bus.clr_ovf = 1'b1;
      push(8'hBB);
      bus.clr_ovf = 1'b0;
      chk("set_beats_clr", {31'd0, bus.overflow}, 32'd1);
      bus.clr_ovf = 1'b1;
      @(negedge clk);
      bus.clr_ovf = 1'b0;
      chk("clr_ovf", {31'd0, bus.overflow}, 32'd0);
      chk("clr_full", {31'd0, bus.full}, 32'd1);

      ack_dly_max = 2;
      busy_min    = 2;
      busy_max    = 6;
      ack_en      = 1'b1;
      wait_drain("drain_burst");
      chk("burst_frames", n_rx, 32'd17);

      // Write lands on the same edge as a pop: count holds at 1.
      ack_en = 1'b0;
      push_q(8'h31);
      @(negedge clk);
      push_q(8'h32);
      chk("pp_pre_count", {27'd0, bus.count}, 32'd1);
      ack_dly_max = 0;
      busy_min    = 1;
      busy_max    = 1;
      ack_en      = 1'b1;
      repeat (3) @(negedge clk);
      push_q(8'h33);
      chk("pp_count", {27'd0, bus.count}, 32'd1);
      chk("pp_start", {31'd0, bus.tx_start}, 32'd1);
      chk("pp_data", {24'd0, bus.tx_data}, 32'h32);
      ack_dly_max = 2;
      busy_max    = 5;
      wait_drain("drain_pp");

      // Random stream of 40 bytes, wrapping the pointers.
      wrote = 0;
      t = 0;
      while (wrote < 40 && t < 5000) begin
         if ($urandom_range(1, 0) == 1 && (n_sent - n_rx) < 8) begin
            push_q(8'($urandom));
            wrote++;
         end else begin
            @(negedge clk);
         end
         t++;
      end
      chk("stream_written", wrote, 32'd40);
      wait_drain("drain_stream");

      // Reset in the middle of a long frame.
      ack_dly_max = 0;
      busy_min    = 20;
      busy_max    = 20;
      for (int i = 0; i < 4; i++) push_q(8'hE0 + i[7:0]);
      t = 0;
      while (!bus.tx_busy && t < 50) begin
         @(negedge clk);
         t++;
      end
      chk("mid_frame", {31'd0, bus.tx_busy}, 32'd1);
      rst_n = 1'b0;
      #1;
      chk("mr_full", {31'd0, bus.full}, 32'd0);
      chk("mr_empty", {31'd0, bus.empty}, 32'd1);
      chk("mr_count", {27'd0, bus.count}, 32'd0);
      chk("mr_ovf", {31'd0, bus.overflow}, 32'd0);
      chk("mr_start", {31'd0, bus.tx_start}, 32'd0);
      chk("mr_data", {24'd0, bus.tx_data}, 32'd0);
      exp_q.delete();
      n_sent = 0;
      n_rx   = 0;
      repeat (2) @(negedge clk);
      rst_n    = 1'b1;
      busy_min = 2;
      busy_max = 4;
      @(negedge clk);
      push_q(8'hC3);
      wait_drain("drain_after_rst");
      chk("post_rst_frames", n_rx, 32'd1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

endmodule
